// File: rtl/div_iter.sv
// Multi-cycle signed divider: restoring shift-subtract, one quotient bit
// per clock, truncating toward zero with saturation on overflow.
module div_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] Rs,
    input  logic [WIDTH-1:0] Rt,
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             V,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [3:0]       LAST    = 4'(WIDTH - 1);

    state_t           state;
    logic [3:0]       count;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   dsr;
    logic [WIDTH-1:0] rs_l;
    logic             neg_s;
    logic             neg_t;
    logic             divz;
    logic             ovf;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             fits;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    always_comb begin
        rem_sh = {rem, dvd[WIDTH-1]};
        trial  = {1'b0, rem_sh} - {1'b0, dsr};
        // a non-negative trial is always below the divisor, so bit WIDTH is 0
        fits   = ~|trial[WIDTH+1:WIDTH];
        q_fix  = (neg_s ^ neg_t) ? -dvd : dvd;
        r_fix  = neg_s ? -rem : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            dvd   <= '0;
            rem   <= '0;
            dsr   <= '0;
            rs_l  <= '0;
            neg_s <= 1'b0;
            neg_t <= 1'b0;
            divz  <= 1'b0;
            ovf   <= 1'b0;
            Quot  <= '0;
            Rem   <= '0;
            V     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // two's-complement negate of the minimum value is exact
                        dvd   <= Rs[WIDTH-1] ? -Rs : Rs;
                        dsr   <= {1'b0, Rt[WIDTH-1] ? -Rt : Rt};
                        rs_l  <= Rs;
                        neg_s <= Rs[WIDTH-1];
                        neg_t <= Rt[WIDTH-1];
                        divz  <= (Rt == '0);
                        ovf   <= (Rs == SAT_NEG) && (Rt == '1);
                        rem   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (fits) begin
                        rem <= trial[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh[WIDTH-1:0];
                        dvd <= {dvd[WIDTH-2:0], 1'b0};
                    end
                    count <= count + 4'd1;
                    if (count == LAST)
                        state <= FIX;
                end
                FIX: begin
                    if (divz) begin
                        Quot <= neg_s ? SAT_NEG : SAT_POS;
                        Rem  <= rs_l;
                        V    <= 1'b1;
                    end else if (ovf) begin
                        Quot <= SAT_POS;
                        Rem  <= '0;
                        V    <= 1'b1;
                    end else begin
                        Quot <= q_fix;
                        Rem  <= r_fix;
                        V    <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
